// File: rtl/pe_stream_pkg.sv
// Shared definitions for the protocol-engine stream register stages.
//  - frm_state_t : packet framing FSM states
//  - payld_w()   : width of the packed beat carried through the skid buffer
//  - *_lsb/_bit  : field offsets inside that packed beat, laid out MSB first as
//                  {tstart, tlast, tkeep, tuser, tdata}
package pe_stream_pkg;

  typedef enum logic [1:0] {
    SOP    = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } frm_state_t;

  function automatic int payld_w(input int tuser_w, input int tdata_w, input int tkeep_w);
    return tuser_w + tdata_w + tkeep_w + 2;
  endfunction

  function automatic int tuser_lsb(input int tdata_w);
    return tdata_w;
  endfunction

  function automatic int tkeep_lsb(input int tuser_w, input int tdata_w);
    return tdata_w + tuser_w;
  endfunction

  function automatic int tlast_bit(input int tuser_w, input int tdata_w, input int tkeep_w);
    return tdata_w + tuser_w + tkeep_w;
  endfunction

  function automatic int tstart_bit(input int tuser_w, input int tdata_w, input int tkeep_w);
    return tdata_w + tuser_w + tkeep_w + 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf_2e.sv
// Two-entry skid buffer with registered ready on the upstream side and
// registered valid/payload on the downstream side.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   up_vld/up_rdy/up_payld   upstream beat (up_rdy is a flop)
//   dn_vld/dn_rdy/dn_payld   downstream beat (payload reads 0 while dn_vld=0)
module stream_skid_buf_2e #(
  parameter int PAYLD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_vld,
  output logic               up_rdy,
  input  logic [PAYLD_W-1:0] up_payld,
  output logic               dn_vld,
  input  logic               dn_rdy,
  output logic [PAYLD_W-1:0] dn_payld
);

  // head entry drives the downstream port; skid entry catches the beat that
  // arrives while the head is stalled.
  logic               head_vld_reg, head_vld_next;
  logic [PAYLD_W-1:0] head_payld_reg, head_payld_next;
  logic               skid_vld_reg, skid_vld_next;
  logic [PAYLD_W-1:0] skid_payld_reg, skid_payld_next;
  logic               rdy_reg, rdy_next;
  logic               push, pop;

  always_comb begin
    push            = up_vld & rdy_reg;
    pop             = head_vld_reg & dn_rdy;
    head_vld_next   = head_vld_reg;
    head_payld_next = head_payld_reg;
    skid_vld_next   = skid_vld_reg;
    skid_payld_next = skid_payld_reg;

    // rdy_reg is low whenever both entries are full, so push never coincides
    // with a pop that still has a skid entry to move forward.
    if (pop) begin
      if (skid_vld_reg) begin
        head_payld_next = skid_payld_reg;
        skid_vld_next   = 1'b0;
        skid_payld_next = '0;
      end else if (push) begin
        head_payld_next = up_payld;
      end else begin
        head_vld_next   = 1'b0;
        head_payld_next = '0;
      end
    end else if (push) begin
      if (head_vld_reg) begin
        skid_vld_next   = 1'b1;
        skid_payld_next = up_payld;
      end else begin
        head_vld_next   = 1'b1;
        head_payld_next = up_payld;
      end
    end

    // Ready is the registered "fewer than two entries next cycle" flag.
    rdy_next = ~(head_vld_next & skid_vld_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_vld_reg   <= 1'b0;
      head_payld_reg <= '0;
      skid_vld_reg   <= 1'b0;
      skid_payld_reg <= '0;
      rdy_reg        <= 1'b0;
    end else begin
      head_vld_reg   <= head_vld_next;
      head_payld_reg <= head_payld_next;
      skid_vld_reg   <= skid_vld_next;
      skid_payld_reg <= skid_payld_next;
      rdy_reg        <= rdy_next;
    end
  end

  assign up_rdy   = rdy_reg;
  assign dn_vld   = head_vld_reg;
  assign dn_payld = head_payld_reg;

endmodule

// File: rtl/stream_out_reg_for_protocol_engine.sv
// Egress register stage of the protocol engine. Frames engine beats into
// packets (tstart generation, per-packet tuser, truncation of packets longer
// than MAX_BEATS) and drives the downstream AXIS-like port via a 2-entry skid
// buffer.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   out_reg_t{valid,last,user,data,keep}, out_reg_tready   engine side
//   axis_t{valid,start,last,user,data,keep}, axis_tready   downstream side
//   pkt_cnt        packets accepted downstream (wrapping)
//   err_overlong   one-cycle pulse when a packet is truncated
module stream_out_reg_for_protocol_engine
  import pe_stream_pkg::*;
#(
  parameter int TUSER_WIDTH = 128,
  parameter int TDATA_WIDTH = 256,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int MAX_BEATS   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   out_reg_tvalid,
  input  logic                   out_reg_tlast,
  input  logic [TUSER_WIDTH-1:0] out_reg_tuser,
  input  logic [TDATA_WIDTH-1:0] out_reg_tdata,
  input  logic [TKEEP_WIDTH-1:0] out_reg_tkeep,
  output logic                   out_reg_tready,
  output logic                   axis_tvalid,
  output logic                   axis_tstart,
  output logic                   axis_tlast,
  output logic [TUSER_WIDTH-1:0] axis_tuser,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic [TKEEP_WIDTH-1:0] axis_tkeep,
  input  logic                   axis_tready,
  output logic [31:0]            pkt_cnt,
  output logic                   err_overlong
);

  localparam int PAYLD_W    = payld_w(TUSER_WIDTH, TDATA_WIDTH, TKEEP_WIDTH);
  localparam int TUSER_LSB  = tuser_lsb(TDATA_WIDTH);
  localparam int TKEEP_LSB  = tkeep_lsb(TUSER_WIDTH, TDATA_WIDTH);
  localparam int TLAST_BIT  = tlast_bit(TUSER_WIDTH, TDATA_WIDTH, TKEEP_WIDTH);
  localparam int TSTART_BIT = tstart_bit(TUSER_WIDTH, TDATA_WIDTH, TKEEP_WIDTH);
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  frm_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next, cnt_inc;
  logic [TUSER_WIDTH-1:0] tuser_reg, tuser_next;
  logic [31:0]            pkt_cnt_reg, pkt_cnt_next;
  logic                   err_reg, err_next;

  logic                   accept;
  logic                   beat_tstart, beat_tlast;
  logic [TUSER_WIDTH-1:0] beat_tuser;
  logic                   buf_up_vld, buf_up_rdy;
  logic [PAYLD_W-1:0]     buf_up_payld, buf_dn_payld;
  logic                   buf_dn_vld;

  always_comb begin
    accept        = out_reg_tvalid & buf_up_rdy;
    cnt_inc       = beat_cnt_reg + CNT_W'(1);
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    tuser_next    = tuser_reg;
    err_next      = 1'b0;
    beat_tstart   = 1'b0;
    beat_tlast    = out_reg_tlast;
    beat_tuser    = tuser_reg;
    // Beats in DROP are accepted upstream but never enter the buffer.
    buf_up_vld    = out_reg_tvalid && (state_reg != DROP);

    case (state_reg)
      SOP: begin
        beat_tstart = 1'b1;
        beat_tuser  = out_reg_tuser;
        if (accept) begin
          tuser_next    = out_reg_tuser;
          beat_cnt_next = CNT_W'(1);
          state_next    = out_reg_tlast ? SOP : IN_PKT;
        end
      end
      IN_PKT: begin
        // MAX_BEATS-th beat without a real tlast closes the packet early.
        if (!out_reg_tlast && cnt_inc == MAX_CNT) beat_tlast = 1'b1;
        if (accept) begin
          beat_cnt_next = cnt_inc;
          if (out_reg_tlast) begin
            state_next = SOP;
          end else if (cnt_inc == MAX_CNT) begin
            state_next = DROP;
            err_next   = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && out_reg_tlast) state_next = SOP;
      end
      default: state_next = SOP;
    endcase

    pkt_cnt_next = pkt_cnt_reg + 32'(buf_dn_vld & axis_tready & axis_tlast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= SOP;
      beat_cnt_reg <= '0;
      tuser_reg    <= '0;
      pkt_cnt_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      tuser_reg    <= tuser_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign buf_up_payld = {beat_tstart, beat_tlast, out_reg_tkeep, beat_tuser, out_reg_tdata};

  stream_skid_buf_2e #(
    .PAYLD_W (PAYLD_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (buf_up_vld),
    .up_rdy   (buf_up_rdy),
    .up_payld (buf_up_payld),
    .dn_vld   (buf_dn_vld),
    .dn_rdy   (axis_tready),
    .dn_payld (buf_dn_payld)
  );

  assign out_reg_tready = buf_up_rdy;
  assign axis_tvalid    = buf_dn_vld;
  assign axis_tstart    = buf_dn_payld[TSTART_BIT];
  assign axis_tlast     = buf_dn_payld[TLAST_BIT];
  assign axis_tkeep     = buf_dn_payld[TKEEP_LSB +: TKEEP_WIDTH];
  assign axis_tuser     = buf_dn_payld[TUSER_LSB +: TUSER_WIDTH];
  assign axis_tdata     = buf_dn_payld[0 +: TDATA_WIDTH];
  assign pkt_cnt        = pkt_cnt_reg;
  assign err_overlong   = err_reg;

endmodule

// File: tb/tb_stream_out_reg_for_protocol_engine.sv
// Scoreboard bench for stream_out_reg_for_protocol_engine: the stimulus side
// pushes the expected downstream beat for every accepted upstream beat, and a
// negedge monitor pops and compares each beat accepted downstream.
module tb_stream_out_reg_for_protocol_engine;

  localparam int TU = 16;
  localparam int TD = 32;
  localparam int TK = 4;
  localparam int MB = 8;

  typedef struct packed {
    logic          tstart;
    logic          tlast;
    logic [TU-1:0] tuser;
    logic [TD-1:0] tdata;
    logic [TK-1:0] tkeep;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          out_reg_tvalid, out_reg_tlast, out_reg_tready;
  logic [TU-1:0] out_reg_tuser;
  logic [TD-1:0] out_reg_tdata;
  logic [TK-1:0] out_reg_tkeep;
  logic          axis_tvalid, axis_tstart, axis_tlast, axis_tready;
  logic [TU-1:0] axis_tuser;
  logic [TD-1:0] axis_tdata;
  logic [TK-1:0] axis_tkeep;
  logic [31:0]   pkt_cnt;
  logic          err_overlong;

  always #5 clk = ~clk;

  stream_out_reg_for_protocol_engine #(
    .TUSER_WIDTH (TU),
    .TDATA_WIDTH (TD),
    .TKEEP_WIDTH (TK),
    .MAX_BEATS   (MB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .out_reg_tvalid (out_reg_tvalid),
    .out_reg_tlast  (out_reg_tlast),
    .out_reg_tuser  (out_reg_tuser),
    .out_reg_tdata  (out_reg_tdata),
    .out_reg_tkeep  (out_reg_tkeep),
    .out_reg_tready (out_reg_tready),
    .axis_tvalid    (axis_tvalid),
    .axis_tstart    (axis_tstart),
    .axis_tlast     (axis_tlast),
    .axis_tuser     (axis_tuser),
    .axis_tdata     (axis_tdata),
    .axis_tkeep     (axis_tkeep),
    .axis_tready    (axis_tready),
    .pkt_cnt        (pkt_cnt),
    .err_overlong   (err_overlong)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    in_acc = 0;
  int    out_beats = 0;
  int    err_cnt = 0;
  int    data_seq = 1;
  int    out_cyc [512];
  bit    rst_at_edge = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t exp_q [$];

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    got = {axis_tstart, axis_tlast, axis_tuser, axis_tdata, axis_tkeep};
    if (out_reg_tvalid && out_reg_tready) in_acc++;
    if (err_overlong) err_cnt++;
    if (prev_stall && !rst_at_edge) begin
      check("hold_valid", 64'(axis_tvalid), 64'd1);
      check("hold_payload", 64'(got), 64'(prev_beat));
    end
    if (axis_tvalid && axis_tready) begin
      if (out_beats < 512) out_cyc[out_beats] = cyc;
      out_beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h, expected no beat", got);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL scoreboard_beat: got st=%0b la=%0b u=%h d=%h k=%h, expected st=%0b la=%0b u=%h d=%h k=%h",
                   got.tstart, got.tlast, got.tuser, got.tdata, got.tkeep,
                   e.tstart, e.tlast, e.tuser, e.tdata, e.tkeep);
        end else begin
          $display("beat %0d cyc %0d: tstart=%0b tlast=%0b tuser=%h tdata=%h tkeep=%h",
                   out_beats - 1, cyc, got.tstart, got.tlast, got.tuser, got.tdata, got.tkeep);
        end
      end
    end else if (!axis_tvalid) begin
      check("idle_zero", 64'(got), 64'd0);
    end
    prev_stall = axis_tvalid && !axis_tready;
    prev_beat  = got;
  end

  // Drive one beat and hold it until accepted; called at posedge+1.
  task automatic drive_beat(input logic last, input logic [TU-1:0] u, input logic [TD-1:0] d,
                            input logic [TK-1:0] k, output int acc_cyc, output bit ok);
    int n;
    bit acc;
    out_reg_tvalid = 1'b1;
    out_reg_tlast  = last;
    out_reg_tuser  = u;
    out_reg_tdata  = d;
    out_reg_tkeep  = k;
    n   = 0;
    acc = 1'b0;
    ok  = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = out_reg_tready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_accept_timeout: got no ready in %0d cycles, expected ready", n);
        ok = 1'b0;
        break;
      end
    end
    acc_cyc        = cyc;
    out_reg_tvalid = 1'b0;
  endtask

  // Send an n-beat packet; expected output follows the framing rules.
  task automatic send_pkt(input int n, input logic [TU-1:0] u0, input bit vary, output int last_acc);
    for (int i = 0; i < n; i++) begin
      logic [TU-1:0] u;
      logic [TD-1:0] d;
      logic [TK-1:0] k;
      bit            ok;
      beat_t         e;
      u = vary ? u0 + TU'(i) : u0;
      d = TD'(data_seq);
      data_seq++;
      k = TK'(15 - (i % 16));
      drive_beat(i == n - 1, u, d, k, last_acc, ok);
      if (ok && i < MB) begin
        e.tstart = (i == 0);
        e.tlast  = (i == n - 1) || (i == MB - 1);
        e.tuser  = u0;
        e.tdata  = d;
        e.tkeep  = k;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc;
    int  b0;
    int  a0;
    int  n;
    bit  ok;
    bit  done;
    rst_n          = 1'b0;
    out_reg_tvalid = 1'b0;
    out_reg_tlast  = 1'b0;
    out_reg_tuser  = '0;
    out_reg_tdata  = '0;
    out_reg_tkeep  = '0;
    axis_tready    = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", 64'(out_reg_tready), 64'd0);
    check("reset_tvalid", 64'(axis_tvalid), 64'd0);
    check("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("reset_err", 64'(err_overlong), 64'd0);
    check("reset_tdata", 64'(axis_tdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_tready", 64'(out_reg_tready), 64'd1);

    // 1-beat packet, 1-cycle latency
    b0 = out_beats;
    send_pkt(1, 16'h00A5, 1'b0, acc);
    drain();
    check("t1_latency", 64'(out_cyc[b0]), 64'(acc));
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // 4-beat packet with changing tuser on later beats
    send_pkt(4, 16'h0001, 1'b1, acc);
    drain();
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Back-to-back 8-beat packets (length == MAX_BEATS, legal)
    b0 = out_beats;
    send_pkt(8, 16'h0B0B, 1'b0, acc);
    send_pkt(8, 16'h0C0C, 1'b0, acc);
    drain();
    check("b2b_span", 64'(out_cyc[b0 + 15] - out_cyc[b0]), 64'd15);
    check("b2b_pkt_cnt", 64'(pkt_cnt), 64'd4);
    check("b2b_no_err", 64'(err_cnt), 64'd0);

    // Downstream stall for 5 cycles mid-stream
    axis_tready = 1'b0;
    a0   = in_acc;
    done = 1'b0;
    fork
      begin
        int c;
        send_pkt(6, 16'h0D0D, 1'b0, c);
        done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("stall_in_acc", 64'(in_acc - a0), 64'd2);
    check("stall_tready", 64'(out_reg_tready), 64'd0);
    check("stall_tvalid", 64'(axis_tvalid), 64'd1);
    axis_tready = 1'b1;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_sender_done", 64'(done), 64'd1);
    drain();
    check("stall_pkt_cnt", 64'(pkt_cnt), 64'd5);

    // Overlong packet (10 beats, MAX_BEATS=8) then a normal packet
    send_pkt(10, 16'h0E0E, 1'b0, acc);
    send_pkt(1, 16'h0F0F, 1'b0, acc);
    drain();
    check("overlong_err_pulses", 64'(err_cnt), 64'd1);
    check("overlong_pkt_cnt", 64'(pkt_cnt), 64'd7);

    // Reset mid-packet with beats sitting in the buffer
    axis_tready = 1'b0;
    drive_beat(1'b0, 16'h1111, TD'(32'hDEAD0001), 4'hF, acc, ok);
    drive_beat(1'b0, 16'h1111, TD'(32'hDEAD0002), 4'hF, acc, ok);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_tvalid", 64'(axis_tvalid), 64'd0);
    check("midrst_tready", 64'(out_reg_tready), 64'd0);
    check("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("midrst_tdata", 64'(axis_tdata), 64'd0);
    check("midrst_tstart", 64'(axis_tstart), 64'd0);
    exp_q.delete();
    axis_tready = 1'b1;
    send_pkt(1, 16'h2222, 1'b0, acc);
    drain();
    check("midrst_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
